// File: rtl/rca_bist_checker.sv
// Output-response analyser for the ripple-carry adder BIST path: compares the adder
// under test against a golden sum. Optional macro BIST_EARLY_ABORT_EN ends a session at its first mismatch.
module rca_bist_checker #(
    parameter int WIDTH = 5,
    parameter int NVEC  = 8,
    parameter int CW    = 4
) (
    input  logic             clk,
    input  logic             init,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_1,
    input  logic [WIDTH-1:0] sum,
    input  logic             cout,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [NVEC-1:0]  fail_mask,
    output logic [WIDTH:0]   fault_slice,
    output logic [CW-1:0]    err_count
);

    localparam int            IW       = (NVEC > 1) ? $clog2(NVEC) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(NVEC - 1);
    localparam logic [CW-1:0] ERR_MAX  = '1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [IW-1:0]    vec_idx;
    logic [WIDTH:0]   exp_res;
    logic [WIDTH:0]   obs_res;
    logic [WIDTH:0]   diff;
    logic             mismatch;
    logic             last_vec;
    logic             accept;
    logic             sample;
    logic             finish;

    // Golden result keeps the carry: WIDTH+1 bits, compared against {cout,sum}.
    always_comb begin
        exp_res  = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, c_1};
        obs_res  = {cout, sum};
        diff     = exp_res ^ obs_res;
        mismatch = |diff;
        last_vec = (vec_idx == LAST_IDX);
        accept   = (state == S_IDLE) && start;
        sample   = (state == S_RUN);
`ifdef BIST_EARLY_ABORT_EN
        finish   = sample && (last_vec || mismatch);
`else
        finish   = sample && last_vec;
`endif
    end

    assign busy = (state == S_RUN);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge init) begin
        if (!init) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: state_next gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: if (start) state_next = S_RUN;
            S_RUN:  if (finish) state_next = S_DONE;
            S_DONE: state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // Result registers: cleared on an accepted start, updated once per RUN cycle,
    // otherwise held so the reconfiguration logic can read them in IDLE.
    always_ff @(posedge clk or negedge init) begin
        if (!init) begin
            vec_idx     <= '0;
            done        <= 1'b0;
            pass        <= 1'b0;
            fail_mask   <= '0;
            fault_slice <= '0;
            err_count   <= '0;
        end else begin
            done <= (state == S_DONE);
            if (accept) begin
                vec_idx     <= '0;
                pass        <= 1'b0;
                fail_mask   <= '0;
                fault_slice <= '0;
                err_count   <= '0;
            end else if (sample) begin
                if (mismatch) begin
                    fail_mask   <= fail_mask | (NVEC'(1) << vec_idx);
                    fault_slice <= fault_slice | diff;
                    if (err_count != ERR_MAX) begin
                        err_count <= err_count + CW'(1);
                    end
                end
                if (!last_vec) begin
                    vec_idx <= vec_idx + IW'(1);
                end
                // err_count is still the pre-update value here, so fold in this cycle's compare.
                if (finish) begin
                    pass <= (err_count == '0) && !mismatch;
                end
            end
        end
    end

endmodule

// File: tb/tb_rca_bist_checker.sv
// Directed bench for rca_bist_checker: a behavioural adder with selectable stuck-at
// faults feeds 8-vector sessions; expected results are hand-computed per table.
module tb_rca_bist_checker;

    localparam int WIDTH = 5;
    localparam int NVEC  = 8;
    localparam int CW    = 4;

    logic             clk;
    logic             init;
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             c_1;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             busy;
    logic             done;
    logic             pass;
    logic [NVEC-1:0]  fail_mask;
    logic [WIDTH:0]   fault_slice;
    logic [CW-1:0]    err_count;

    logic             sat_busy;
    logic             sat_done;
    logic             sat_pass;
    logic [NVEC-1:0]  sat_fail_mask;
    logic [WIDTH:0]   sat_fault_slice;
    logic [1:0]       sat_err_count;

    int checks   = 0;
    int failures = 0;

    // 0: fault-free, 1: sum bit 2 stuck-at-0, 2: cout stuck-at-1
    int             fault = 0;
    logic [WIDTH:0] full;
    logic [4:0]     va [8];
    logic [4:0]     vb [8];
    logic           vc [8];

    rca_bist_checker #(.WIDTH(WIDTH), .NVEC(NVEC), .CW(CW)) dut (
        .clk(clk), .init(init), .start(start), .a(a), .b(b), .c_1(c_1),
        .sum(sum), .cout(cout), .busy(busy), .done(done), .pass(pass),
        .fail_mask(fail_mask), .fault_slice(fault_slice), .err_count(err_count)
    );

    // Narrow counter instance, only used to observe saturation.
    rca_bist_checker #(.WIDTH(WIDTH), .NVEC(NVEC), .CW(2)) dut_sat (
        .clk(clk), .init(init), .start(start), .a(a), .b(b), .c_1(c_1),
        .sum(sum), .cout(cout), .busy(sat_busy), .done(sat_done), .pass(sat_pass),
        .fail_mask(sat_fail_mask), .fault_slice(sat_fault_slice), .err_count(sat_err_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always_comb begin
        full = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, c_1};
        sum  = full[WIDTH-1:0];
        cout = full[WIDTH];
        if (fault == 1) sum[2] = 1'b0;
        if (fault == 2) cout = 1'b1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_vec(input int sel);
        case (sel)
            0: begin  // exercises sum bit 2 on vectors 1,3,4,6
                va = '{5'd0, 5'd4, 5'd1, 5'd2, 5'd3, 5'd7, 5'd31, 5'd16};
                vb = '{5'd0, 5'd0, 5'd1, 5'd2, 5'd1, 5'd1, 5'd31, 5'd8};
                vc = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
            end
            1: begin  // true carry-out is 0 on vectors 0,2,4,6
                va = '{5'd0, 5'd31, 5'd1, 5'd16, 5'd5, 5'd31, 5'd0, 5'd20};
                vb = '{5'd0, 5'd1, 5'd2, 5'd16, 5'd5, 5'd31, 5'd0, 5'd12};
                vc = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
            end
            2: begin  // carry-out never set
                va = '{5'd0, 5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6, 5'd7};
                vb = '{5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0};
                vc = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
            end
            default: begin  // first sum-bit-2 hit at vector 2
                va = '{5'd0, 5'd1, 5'd4, 5'd4, 5'd2, 5'd3, 5'd4, 5'd0};
                vb = '{5'd0, 5'd1, 5'd0, 5'd0, 5'd2, 5'd0, 5'd0, 5'd0};
                vc = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
            end
        endcase
    endtask

    // Starts a session from IDLE and returns start-to-done latency in edges (0 on
    // timeout) and the number of cycles busy was high; ends in the done cycle.
    task automatic run_session(input int start_again_at, output int lat, output int busy_cycles);
        bit got;
        got = 0;
        lat = 0;
        busy_cycles = 0;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int cyc = 1; cyc <= 20 && !got; cyc++) begin
            if (cyc - 1 < NVEC) begin
                a   = va[cyc-1];
                b   = vb[cyc-1];
                c_1 = vc[cyc-1];
            end else begin
                a   = '0;
                b   = '0;
                c_1 = 1'b0;
            end
            start = (cyc - 1 == start_again_at);
            if (busy) busy_cycles++;
            tick();
            start = 1'b0;
            if (done) begin
                got = 1;
                lat = cyc;
            end
        end
    endtask

    task automatic check_session(input string name, input int lat, input int bcyc, input int exp_lat,
                                 input int exp_busy, input logic [18:0] exp_res);
        logic [18:0] res;
        res = {pass, fail_mask, fault_slice, err_count};
        checks++;
        if (lat !== exp_lat) begin
            failures++;
            $display("FAIL %s_latency: got %0d expected %0d", name, lat, exp_lat);
        end
        checks++;
        if (bcyc !== exp_busy) begin
            failures++;
            $display("FAIL %s_busy_cycles: got %0d expected %0d", name, bcyc, exp_busy);
        end
        checks++;
        if (res !== exp_res) begin
            failures++;
            $display("FAIL %s_results {pass,mask,slice,err}: got %b expected %b", name, res, exp_res);
        end
    endtask

    task automatic test_reset();
        init  = 1'b0;
        start = 1'b0;
        a     = '0;
        b     = '0;
        c_1   = 1'b0;
        #12;
        checks++;
        if ({busy, done, pass, fail_mask, fault_slice, err_count} !== 21'd0) begin
            failures++;
            $display("FAIL reset_outputs: got %b expected all zero",
                     {busy, done, pass, fail_mask, fault_slice, err_count});
        end
        init = 1'b1;
        tick();
        tick();
        checks++;
        if ({busy, done} !== 2'b00) begin
            failures++;
            $display("FAIL reset_idle: busy/done got %b expected 00", {busy, done});
        end
    endtask

    task automatic test_fault_free();
        int lat, bc;
        fault = 0;
        load_vec(0);
        run_session(-1, lat, bc);
        check_session("fault_free", lat, bc, 9, 8, {1'b1, 8'h00, 6'h00, 4'd0});
        tick();
        tick();
        checks++;
        if ({done, busy, pass} !== 3'b001) begin
            failures++;
            $display("FAIL hold_in_idle: {done,busy,pass} got %b expected 001", {done, busy, pass});
        end
    endtask

    task automatic test_sum_bit2_sa0();
        int lat, bc;
        fault = 1;
        load_vec(0);
        run_session(-1, lat, bc);
        check_session("sum2_sa0", lat, bc, 9, 8, {1'b0, 8'h5A, 6'b000100, 4'd4});
        tick();
    endtask

    task automatic test_cout_sa1();
        int lat, bc;
        fault = 2;
        load_vec(1);
        run_session(-1, lat, bc);
        check_session("cout_sa1", lat, bc, 9, 8, {1'b0, 8'h55, 6'h20, 4'd4});
        tick();
    endtask

    task automatic test_saturation();
        int lat, bc;
        fault = 2;
        load_vec(2);
        run_session(-1, lat, bc);
        check_session("all_fail", lat, bc, 9, 8, {1'b0, 8'hFF, 6'h20, 4'd8});
        checks++;
        if (sat_err_count !== 2'd3) begin
            failures++;
            $display("FAIL err_saturate: got %0d expected 3", sat_err_count);
        end
        tick();
    endtask

    task automatic test_start_ignored();
        int lat, bc;
        fault = 1;
        load_vec(0);
        run_session(3, lat, bc);
        check_session("start_in_run", lat, bc, 9, 8, {1'b0, 8'h5A, 6'b000100, 4'd4});
        tick();
        fault = 0;
        run_session(8, lat, bc);
        check_session("start_in_done", lat, bc, 9, 8, {1'b1, 8'h00, 6'h00, 4'd0});
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL start_in_done_not_queued: busy got %b expected 0", busy);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        int lat, bc;
        fault = 0;
        load_vec(0);
        run_session(-1, lat, bc);
        // second start issued in the done cycle, accepted on the very next edge
        fault = 1;
        run_session(-1, lat, bc);
        check_session("back_to_back", lat, bc, 9, 8, {1'b0, 8'h5A, 6'b000100, 4'd4});
        tick();
        // a previously passing result must be wiped by the accepting edge
        fault = 0;
        run_session(-1, lat, bc);
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        checks++;
        if ({busy, pass, fail_mask, fault_slice, err_count} !== 20'h80000) begin
            failures++;
            $display("FAIL start_clears: {busy,pass,mask,slice,err} got %b expected busy only",
                     {busy, pass, fail_mask, fault_slice, err_count});
        end
        for (int i = 0; i < 12 && !done; i++) tick();
        tick();
    endtask

    task automatic test_reset_mid_run();
        int lat, bc;
        fault = 2;
        load_vec(1);
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            a   = va[i];
            b   = vb[i];
            c_1 = vc[i];
            tick();
        end
        checks++;
        if ({fail_mask, err_count} !== {8'h05, 4'd2}) begin
            failures++;
            $display("FAIL partial_before_reset: {mask,err} got %h expected 052", {fail_mask, err_count});
        end
        a   = va[4];
        b   = vb[4];
        c_1 = vc[4];
        #2 init = 1'b0;
        #1;
        checks++;
        if ({busy, done, pass, fail_mask, fault_slice, err_count} !== 21'd0) begin
            failures++;
            $display("FAIL mid_reset_outputs: got %b expected all zero",
                     {busy, done, pass, fail_mask, fault_slice, err_count});
        end
        tick();
        #3 init = 1'b1;
        tick();
        tick();
        checks++;
        if ({busy, done, fail_mask, err_count} !== 14'd0) begin
            failures++;
            $display("FAIL after_reset_idle: got %b expected all zero", {busy, done, fail_mask, err_count});
        end
        fault = 0;
        load_vec(0);
        run_session(-1, lat, bc);
        check_session("after_reset", lat, bc, 9, 8, {1'b1, 8'h00, 6'h00, 4'd0});
        tick();
    endtask

    task automatic test_early_abort();
        int lat, bc;
        fault = 1;
        load_vec(3);
        run_session(-1, lat, bc);
        check_session("early_abort", lat, bc, 4, 3, {1'b0, 8'h04, 6'b000100, 4'd1});
        tick();
    endtask

    initial begin
        test_reset();
        test_fault_free();
`ifdef BIST_EARLY_ABORT_EN
        test_early_abort();
`else
        test_sum_bit2_sa0();
        test_cout_sa1();
        test_saturation();
        test_start_ignored();
        test_back_to_back();
`endif
        test_reset_mid_run();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/rca_bist_checker.md
# rca_bist_checker

Output-response analyser for the fault-tolerant ripple-carry adder BIST path. It sits directly downstream of the test pattern generator. Each cycle it takes the generated operands `a`, `b`, carry-in `c_1` and the adder-under-test's `sum`/`cout`, and compares the adder result against an internally computed golden result. Over an NVEC-vector session it accumulates a per-vector fail mask, a per-bit-slice fault map and an error count, which the reconfiguration logic uses to steer around a faulty slice.

## Interface
- `WIDTH`, default 5: operand width; matches the pattern generator.
- `NVEC`, default 8: vectors per session; one full pattern-generator counter period.
- `CW`, default 4: error-count width; must satisfy 2^CW > NVEC.

- `clk`  in  1  system clock; all state updates on the rising edge.
- `init`  in  1  asynchronous, active-low reset.
- `start`  in  1  single-cycle session request; sampled only in IDLE.
- `a`  in  WIDTH  operand A from the pattern generator.
- `b`  in  WIDTH  operand B from the pattern generator.
- `c_1`  in  1  carry-in from the pattern generator.
- `sum`  in  WIDTH  sum from the adder under test (combinational, same cycle as `a`/`b`).
- `cout`  in  1  carry-out from the adder under test.
- `busy`  out  1  high while in RUN.
- `done`  out  1  one-cycle pulse when the session ends.
- `pass`  out  1  high when the last session had zero mismatches; valid from `done` until the next `start`.
- `fail_mask`  out  NVEC  bit i set when vector i mismatched.
- `fault_slice`  out  WIDTH+1  OR over the session of the mismatch bits; bit WIDTH is the carry-out.
- `err_count`  out  CW  number of mismatching vectors, saturating at 2^CW-1.

## Operation
- Golden result: `exp = {1'b0,a} + {1'b0,b} + c_1`, computed at WIDTH+1 bits with no truncation.
- Observed result: `obs = {cout,sum}`.
- Per-cycle difference: `diff = exp ^ obs`. The cycle is a mismatch when `diff` is not all zeros.
- FSM states: IDLE, RUN, DONE.
  - IDLE → RUN when `start`=1. The same edge clears `fail_mask`, `fault_slice`, `err_count` and `pass`, and sets `vec_idx`=0.
  - In RUN, every cycle:
    - samples one vector.
    - on a mismatch, sets `fail_mask[vec_idx]`, ORs `diff` into `fault_slice` and increments `err_count`.
    - increments `vec_idx`.
  - RUN → DONE after the compare at `vec_idx`=NVEC-1.
  - DONE → IDLE unconditionally after one cycle.
- `pass` is registered on entry to DONE as (`err_count`==0 after the final update).
- `start` in RUN or DONE is ignored; it is not queued.
- Results hold their values in IDLE until the next accepted `start`.
- Alignment with the pattern generator is the integrator's job: assert `start` so that RUN cycle 0 coincides with generator count 0.

## Timing
- Reset (`init`=0, asynchronous): state=IDLE, `vec_idx`=0, `busy`=0, `done`=0, `pass`=0, `fail_mask`=0, `fault_slice`=0, `err_count`=0.
- Releasing reset mid-session leaves the block in IDLE with all results cleared; no partial result is retained.
- With `start` seen at edge T:
  - `busy`=1 for edges T+1 through T+NVEC.
  - The inputs sampled at edges T+1…T+NVEC form vectors 0…NVEC-1.
  - `done`=1 and `pass` are valid in the cycle after edge T+NVEC+1.
- Latency from `start` to `done` is NVEC+1 cycles (9 for the defaults).
- The earliest a back-to-back `start` is accepted is in the cycle after `done`.
- A mismatch on the final vector is reflected in `fail_mask`, `fault_slice` and `pass` in the same cycle `done` rises.
- `err_count` saturates and never wraps. `vec_idx` never wraps inside a session.

## Configuration
- `BIST_EARLY_ABORT_EN`
  - Defined: the first mismatch in RUN records its vector and diff as normal, then goes to DONE on the next edge. `done` pulses early, `pass`=0, `err_count`=1, and later vectors are not examined.
  - Undefined: all NVEC vectors are always examined; behaviour is as described above.

## Test plan
- Fault-free adder model, 8 generator vectors, `start` pulsed once → `done` 9 cycles later, `pass`=1, `fail_mask`=8'h00, `fault_slice`=6'h00, `err_count`=0.
- Sum bit 2 stuck-at-0, vectors exercising bit 2 → the corresponding `fail_mask` bits set, `fault_slice`=6'b000100, `pass`=0.
- `cout` stuck-at-1, vector a=5'h00, b=5'h00, c_1=0 at index 0 → `fail_mask[0]`=1, `fault_slice[5]`=1, `err_count`≥1.
- `start` re-asserted at RUN cycle 3 → ignored; `done` still exactly 9 cycles after the first `start`, with the counts unchanged.
- `init` dropped at RUN cycle 4, then released, then a new `start` → all outputs read 0 during reset, and the new session completes normally.
- With `BIST_EARLY_ABORT_EN` defined, the first mismatch at vector 2 → `done` pulses one cycle after that compare, `fail_mask`=8'h04, `err_count`=1.
